// File: rtl/dither_pkg.sv
// Shared state encoding and geometry defaults for the dither scheduler.
package dither_pkg;

  localparam int unsigned H_ACTIVE_DEF = 320;
  localparam int unsigned V_ACTIVE_DEF = 240;
  localparam int unsigned PIX_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dither_linebuf.sv
// Error line buffer: DEPTH x PIX_W simple dual-port RAM with a registered read.
// Ports: clk_in; write port wr_en_in/wr_addr_in/wr_data_in;
//        read port rd_addr_in -> rd_data_out (one cycle later).
module dither_linebuf
  import dither_pkg::*;
#(
  parameter int unsigned DEPTH = H_ACTIVE_DEF,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_in,
  input  logic             wr_en_in,
  input  logic [AW-1:0]    wr_addr_in,
  input  logic [PIX_W-1:0] wr_data_in,
  input  logic [AW-1:0]    rd_addr_in,
  output logic [PIX_W-1:0] rd_data_out
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem[wr_addr_in] <= wr_data_in;
    end
    rd_data_out <= mem[rd_addr_in];
  end

endmodule

// File: rtl/dither_scheduler.sv
// Frame scheduler for the error-diffusion dither core: walks the grayscale
// frame row by row, aligns read data with the stored error of the previous
// row, and writes the 1-bit results back out.
// Ports: clk_in/rst_n_in; start_in/pause_in control; busy_out/done_out status;
//        frame_rd_* grayscale read port; dith_*_out issue to the core;
//        dith_*_in results from the core; bw_wr_* 1-bit frame write port.
module dither_scheduler
  import dither_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned ROW_GAP    = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             pause_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             frame_rd_en_out,
  output logic [16:0]      frame_rd_addr_out,
  input  logic [7:0]       frame_rd_data_in,
  output logic             dith_valid_out,
  output logic [10:0]      dith_hcount_out,
  output logic [9:0]       dith_vcount_out,
  output logic [PIX_W-1:0] dith_b_out,
  output logic [PIX_W-1:0] dith_e_out,
  input  logic             dith_valid_in,
  input  logic [10:0]      dith_hcount_in,
  input  logic [9:0]       dith_vcount_in,
  input  logic             dith_pixel_in,
  input  logic [7:0]       dith_updated_in,
  output logic             bw_wr_en_out,
  output logic [16:0]      bw_wr_addr_out,
  output logic             bw_wr_data_out
);

  localparam int unsigned AW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LAST = RD_LATENCY - 1;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] gap_q, gap_d;
  logic [16:0] inflight_q, inflight_d;
  logic        issue;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [10:0]           pipe_h [RD_LATENCY];
  logic [9:0]            pipe_v [RD_LATENCY];

  logic             wr_vld_q;
  logic [10:0]      wr_h_q;
  logic [9:0]       wr_v_q;
  logic             wr_pix_q;
  logic [PIX_W-1:0] wr_upd_q;

  logic [10:0]      lb_rd_h;
  logic [PIX_W-1:0] lb_rd_data;

  assign issue = (state_q == ST_ISSUE) && !pause_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      gap_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      gap_q      <= gap_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_ISSUE;
          h_d     = '0;
          v_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          if (h_q == 11'(H_ACTIVE - 1)) begin
            h_d   = '0;
            gap_d = '0;
            if (v_q == 10'(V_ACTIVE - 1)) begin
              v_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              v_d     = v_q + 10'd1;
              state_d = (ROW_GAP == 0) ? ST_ISSUE : ST_GAP;
            end
          end else begin
            h_d = h_q + 11'd1;
          end
        end
      end
      ST_GAP: begin
        if (!pause_in) begin
          if (gap_q == 16'(ROW_GAP - 1)) begin
            state_d = ST_ISSUE;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case ({issue, dith_valid_in})
      2'b10:   inflight_d = inflight_q + 17'd1;
      2'b01:   inflight_d = inflight_q - 17'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  assign busy_out          = (state_q != ST_IDLE);
  assign done_out          = (state_q == ST_DONE);
  assign frame_rd_en_out   = issue;
  assign frame_rd_addr_out = 17'(v_q) * 17'(H_ACTIVE) + 17'(h_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_h[i] <= '0;
        pipe_v[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_h[0]   <= h_q;
      pipe_v[0]   <= v_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_h[i]   <= pipe_h[i-1];
        pipe_v[i]   <= pipe_v[i-1];
      end
    end
  end

  // Line-buffer read is launched one stage before the frame data arrives so
  // its registered output lines up with frame_rd_data_in.
  if (RD_LATENCY >= 2) begin : g_lb_from_pipe
    assign lb_rd_h = pipe_h[RD_LATENCY-2];
  end else begin : g_lb_from_issue
    assign lb_rd_h = h_q;
  end

  assign dith_valid_out  = pipe_vld[LAST];
  assign dith_hcount_out = pipe_vld[LAST] ? pipe_h[LAST] : '0;
  assign dith_vcount_out = pipe_vld[LAST] ? pipe_v[LAST] : '0;
  assign dith_b_out      = pipe_vld[LAST] ? frame_rd_data_in : '0;
  assign dith_e_out      = (pipe_vld[LAST] && (pipe_v[LAST] != '0)) ? lb_rd_data : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_vld_q <= 1'b0;
      wr_h_q   <= '0;
      wr_v_q   <= '0;
      wr_pix_q <= 1'b0;
      wr_upd_q <= '0;
    end else begin
      wr_vld_q <= dith_valid_in;
      wr_h_q   <= dith_hcount_in;
      wr_v_q   <= dith_vcount_in;
      wr_pix_q <= dith_pixel_in;
      wr_upd_q <= dith_updated_in;
    end
  end

  assign bw_wr_en_out   = wr_vld_q;
  assign bw_wr_addr_out = wr_vld_q ? (17'(wr_v_q) * 17'(H_ACTIVE) + 17'(wr_h_q)) : '0;
  assign bw_wr_data_out = wr_vld_q & wr_pix_q;

  dither_linebuf #(
    .DEPTH (H_ACTIVE),
    .AW    (AW)
  ) u_linebuf (
    .clk_in      (clk_in),
    .wr_en_in    (wr_vld_q),
    .wr_addr_in  (AW'(wr_h_q)),
    .wr_data_in  (wr_upd_q),
    .rd_addr_in  (AW'(lb_rd_h)),
    .rd_data_out (lb_rd_data)
  );

endmodule

// File: tb/tb_dither_scheduler.sv
module tb_dither_scheduler;

  localparam int unsigned H   = 4;
  localparam int unsigned V   = 2;
  localparam int unsigned RDL = 2;
  localparam int unsigned GAP = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        pause_in = 1'b0;
  logic        busy_out, done_out, frame_rd_en_out;
  logic [16:0] frame_rd_addr_out;
  logic [7:0]  frame_rd_data_in;
  logic        dith_valid_out;
  logic [10:0] dith_hcount_out;
  logic [9:0]  dith_vcount_out;
  logic [7:0]  dith_b_out, dith_e_out;
  logic        dith_valid_in;
  logic [10:0] dith_hcount_in;
  logic [9:0]  dith_vcount_in;
  logic        dith_pixel_in;
  logic [7:0]  dith_updated_in;
  logic        bw_wr_en_out;
  logic [16:0] bw_wr_addr_out;
  logic        bw_wr_data_out;

  always #5 clk_in = ~clk_in;

  dither_scheduler #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .RD_LATENCY (RDL),
    .ROW_GAP    (GAP)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .pause_in          (pause_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .frame_rd_en_out   (frame_rd_en_out),
    .frame_rd_addr_out (frame_rd_addr_out),
    .frame_rd_data_in  (frame_rd_data_in),
    .dith_valid_out    (dith_valid_out),
    .dith_hcount_out   (dith_hcount_out),
    .dith_vcount_out   (dith_vcount_out),
    .dith_b_out        (dith_b_out),
    .dith_e_out        (dith_e_out),
    .dith_valid_in     (dith_valid_in),
    .dith_hcount_in    (dith_hcount_in),
    .dith_vcount_in    (dith_vcount_in),
    .dith_pixel_in     (dith_pixel_in),
    .dith_updated_in   (dith_updated_in),
    .bw_wr_en_out      (bw_wr_en_out),
    .bw_wr_addr_out    (bw_wr_addr_out),
    .bw_wr_data_out    (bw_wr_data_out)
  );

  // Frame memory: pixel(a) = a * 0x25 (mod 256), returned two cycles after the strobe.
  logic [7:0] mem_s1;
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_s1           <= 8'h00;
      frame_rd_data_in <= 8'h00;
    end else begin
      mem_s1           <= frame_rd_en_out ? 8'(frame_rd_addr_out * 17'h25) : 8'h00;
      frame_rd_data_in <= mem_s1;
    end
  end

  // Dither core stand-in: one cycle latency, pixel = b[7], updated error = b ^ 0x5A.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dith_valid_in   <= 1'b0;
      dith_hcount_in  <= '0;
      dith_vcount_in  <= '0;
      dith_pixel_in   <= 1'b0;
      dith_updated_in <= 8'h00;
    end else begin
      dith_valid_in   <= dith_valid_out;
      dith_hcount_in  <= dith_hcount_out;
      dith_vcount_in  <= dith_vcount_out;
      dith_pixel_in   <= dith_b_out[7];
      dith_updated_in <= dith_b_out ^ 8'h5A;
    end
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int          rd_n = 0, dv_n = 0, bw_n = 0, done_n = 0, done_cyc = 0;
  int          rd_cyc [128];
  logic [16:0] rd_addr [128];
  int          dv_cyc [128];
  logic [7:0]  dv_b [128];
  logic [7:0]  dv_e [128];
  logic [10:0] dv_h [128];
  logic [9:0]  dv_v [128];
  int          bw_cyc [128];
  logic [16:0] bw_addr [128];
  logic        bw_data [128];

  always @(negedge clk_in) begin
    if (frame_rd_en_out) begin
      if (rd_n < 128) begin
        rd_cyc[rd_n]  = cyc;
        rd_addr[rd_n] = frame_rd_addr_out;
      end
      rd_n++;
    end
    if (dith_valid_out) begin
      if (dv_n < 128) begin
        dv_cyc[dv_n] = cyc;
        dv_b[dv_n]   = dith_b_out;
        dv_e[dv_n]   = dith_e_out;
        dv_h[dv_n]   = dith_hcount_out;
        dv_v[dv_n]   = dith_vcount_out;
      end
      dv_n++;
    end
    if (bw_wr_en_out) begin
      if (bw_n < 128) begin
        bw_cyc[bw_n]  = cyc;
        bw_addr[bw_n] = bw_wr_addr_out;
        bw_data[bw_n] = bw_wr_data_out;
      end
      bw_n++;
    end
    if (done_out) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  logic [76:0] all_outs;
  assign all_outs = {busy_out, done_out, frame_rd_en_out, frame_rd_addr_out,
                     dith_valid_out, dith_hcount_out, dith_vcount_out, dith_b_out,
                     dith_e_out, bw_wr_en_out, bw_wr_addr_out, bw_wr_data_out};

  logic [7:0] exp_b   [8] = '{8'h00, 8'h25, 8'h4A, 8'h6F, 8'h94, 8'hB9, 8'hDE, 8'h03};
  logic [7:0] exp_e   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h7F, 8'h10, 8'h35};
  logic       exp_pix [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int base, input int budget);
    for (int i = 0; i < budget && done_n == base; i++) @(negedge clk_in);
    check({nm, "_done_seen"}, 32'(done_n > base), 32'd1);
  endtask

  task automatic wait_reads(input string nm, input int base, input int cnt, input int budget);
    for (int i = 0; i < budget && (rd_n - base) < cnt; i++) @(posedge clk_in);
    check({nm, "_reads_seen"}, 32'((rd_n - base) >= cnt), 32'd1);
  endtask

  task automatic check_frame(input string nm, input int rb, input int vb, input int bb, input int db);
    check({nm, "_rd_count"}, rd_n - rb, 8);
    check({nm, "_bw_count"}, bw_n - bb, 8);
    check({nm, "_done_once"}, done_n - db, 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_rd_addr%0d", nm, k), rd_addr[rb+k], k);
      check($sformatf("%s_b%0d", nm, k), dv_b[vb+k], exp_b[k]);
      check($sformatf("%s_e%0d", nm, k), dv_e[vb+k], exp_e[k]);
      check($sformatf("%s_h%0d", nm, k), dv_h[vb+k], k % 4);
      check($sformatf("%s_v%0d", nm, k), dv_v[vb+k], k / 4);
      check($sformatf("%s_bw_addr%0d", nm, k), bw_addr[bb+k], k);
      check($sformatf("%s_bw_data%0d", nm, k), bw_data[bb+k], exp_pix[k]);
    end
    check({nm, "_done_after_last_bw"}, done_cyc - bw_cyc[bb+7], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rb, vb, bb, db;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_outs_zero", 32'(|all_outs), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("idle_busy", busy_out, 1'b0);

    // Plain 4x2 frame
    rb = rd_n; vb = dv_n; bb = bw_n; db = done_n;
    pulse_start();
    check("a_busy", busy_out, 1'b1);
    wait_done("a", db, 100);
    repeat (4) @(negedge clk_in);
    check_frame("a", rb, vb, bb, db);
    check("a_row_contig", rd_cyc[rb+3] - rd_cyc[rb], 3);
    check("a_row_gap", rd_cyc[rb+4] - rd_cyc[rb+3], GAP + 1);
    check("a_rd_to_valid0", dv_cyc[vb] - rd_cyc[rb], RDL);
    check("a_rd_to_valid7", dv_cyc[vb+7] - rd_cyc[rb+7], RDL);
    check("a_done_latency", done_cyc - rd_cyc[rb], 14);
    check("a_idle_after", busy_out, 1'b0);

    // Pause for 5 cycles after the second read
    rb = rd_n; vb = dv_n; bb = bw_n; db = done_n;
    pulse_start();
    wait_reads("b", rb, 2, 50);
    #1 pause_in = 1'b1;
    repeat (5) @(posedge clk_in);
    check("b_no_reads_paused", rd_n - rb, 2);
    #1 pause_in = 1'b0;
    wait_done("b", db, 100);
    repeat (4) @(negedge clk_in);
    check_frame("b", rb, vb, bb, db);

    // start_in pulsed while busy
    rb = rd_n; vb = dv_n; bb = bw_n; db = done_n;
    pulse_start();
    repeat (2) @(negedge clk_in);
    pulse_start();
    wait_done("c", db, 100);
    repeat (10) @(negedge clk_in);
    check_frame("c", rb, vb, bb, db);
    check("c_idle_after", busy_out, 1'b0);

    // Reset during DRAIN
    rb = rd_n; vb = dv_n; bb = bw_n; db = done_n;
    pulse_start();
    wait_reads("d", rb, 8, 50);
    check("d_busy_in_drain", busy_out, 1'b1);
    #2 rst_n_in = 1'b0;
    #1;
    check("d_rst_outs_zero", 32'(|all_outs), 32'd0);
    bb = bw_n;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("d_no_done", done_n - db, 0);
    check("d_no_bw_after_rst", bw_n - bb, 0);
    check("d_idle", busy_out, 1'b0);

    // Fresh frame after the aborted one
    rb = rd_n; vb = dv_n; bb = bw_n; db = done_n;
    pulse_start();
    wait_done("e", db, 100);
    repeat (4) @(negedge clk_in);
    check_frame("e", rb, vb, bb, db);
    check("e_done_latency", done_cyc - rd_cyc[rb], 14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dither_scheduler.md
DITHER_SCHEDULER -- requirements
Module: dither_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 320: pixels per row.
REQ-002 Parameter V_ACTIVE, default 240: rows per frame.
REQ-003 Parameter RD_LATENCY, default 2: frame-memory read latency in cycles.
REQ-004 Parameter ROW_GAP, default 2: idle cycles inserted between rows.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset.
REQ-006 clk_in  input  1  sole clock.
REQ-007 rst_n_in  input  1  asynchronous active-low reset.
REQ-008 start_in  input  1  frame start request.
REQ-009 pause_in  input  1  throttle; holds issue while high.
REQ-010 busy_out  output  1  frame in progress.
REQ-011 done_out  output  1  one-cycle pulse at frame completion.
REQ-012 frame_rd_en_out  output  1  grayscale frame-memory read strobe.
REQ-013 frame_rd_addr_out  output  17  read address, v*H_ACTIVE+h.
REQ-014 frame_rd_data_in  input  8  read data, valid RD_LATENCY cycles after strobe.
REQ-015 dith_valid_out, dith_hcount_out[10:0], dith_vcount_out[9:0], dith_b_out[7:0], dith_e_out[7:0]  output  pixel issue to the dither core.
REQ-016 dith_valid_in, dith_hcount_in[10:0], dith_vcount_in[9:0], dith_pixel_in[0], dith_updated_in[7:0]  input  dither core results.
REQ-017 bw_wr_en_out  1, bw_wr_addr_out  17, bw_wr_data_out  1  output  1-bit result frame write port.

Function
REQ-018 FSM states: IDLE, ISSUE, GAP, DRAIN, DONE.
REQ-019 IDLE->ISSUE on start_in; start_in is ignored in any other state.
REQ-020 ISSUE: one read per cycle while pause_in is low; h increments 0..H_ACTIVE-1.
REQ-021 At h=H_ACTIVE-1: h wraps to 0, v increments, state ->GAP; after the last pixel (v=V_ACTIVE-1), state ->DRAIN instead.
REQ-022 GAP: no reads for ROW_GAP cycles, then ->ISSUE; pause_in also extends GAP.
REQ-023 pause_in high: no read is issued and h/v freeze; reads already in flight complete normally.
REQ-024 Read data and h/v are delayed RD_LATENCY cycles and drive dith_* outputs: dith_b_out=frame_rd_data_in, dith_e_out=linebuf[h] for v>0, else 0.
REQ-025 dith_valid_out asserts exactly once per issued read; latency from read to dith_valid_out is RD_LATENCY cycles.
REQ-026 On dith_valid_in: linebuf[dith_hcount_in]<=dith_updated_in and bw_wr_en_out=1 with addr from dith_h/vcount_in and data=dith_pixel_in; all in the same cycle, combinational from registered inputs or registered (1 cycle), fixed.
REQ-027 An in-flight counter +1 on each read and -1 on each dith_valid_in; both events in the same cycle leave it unchanged.
REQ-028 DRAIN->DONE when the in-flight counter is 0; DONE lasts 1 cycle with done_out=1, then ->IDLE.
REQ-029 busy_out=1 in ISSUE, GAP, DRAIN and DONE.
REQ-030 Address arithmetic is unsigned 17-bit; H_ACTIVE*V_ACTIVE SHALL be at most 2^17.

Reset
REQ-031 rst_n_in low: state=IDLE; h, v and the in-flight counter are 0; every output is 0; the delay pipeline is cleared; linebuf contents are unspecified.
REQ-032 Reset mid-frame aborts the frame with no done_out pulse; a new start_in is then required.

Structure
REQ-033 Package dither_pkg SHALL hold the state enum, the H_ACTIVE/V_ACTIVE defaults and the PIX_W=8 constant.
REQ-034 Sub-module dither_linebuf SHALL implement the H_ACTIVE x 8 simple dual-port RAM with a 1-cycle read, aligned inside the RD_LATENCY pipeline.

Verification
REQ-035 Scenario: 4x2 frame, RD_LATENCY=2, pause_in=0 -> 8 reads at addresses 0..7, ROW_GAP bubble after address 3, done_out exactly once after the 8th bw write.
REQ-036 Scenario: pause_in high for 5 cycles mid-row -> addresses continue without skip or repeat; total reads=8.
REQ-037 Scenario: row 1 pixel 2 -> dith_e_out equals the dith_updated_in value written for (h=2, v=0); row 0 gives dith_e_out=0.
REQ-038 Scenario: start_in pulsed while busy_out=1 -> no restart, frame completes normally.
REQ-039 Scenario: rst_n_in low during the DRAIN state -> all outputs 0 next edge, no done_out pulse; a subsequent start_in runs a full frame.
REQ-040 Scenario: dither core returning dith_valid_in in the same cycle as a new read -> in-flight count unchanged, DRAIN exits correctly.
